// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Patterns are active low, packed as {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Bit order of a segment word, MSB first.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational code-to-segment decoder. Codes above 9 show letters only
// when hex_en is set; blank overrides everything.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  input  logic       blank,
  output logic [6:0] seg
);

  seg_t hex_seg;

  always_comb begin
    hex_seg = SEG_BLANK;
    case (code)
      4'hA:    hex_seg = SEG_A;
      4'hB:    hex_seg = SEG_B;
      4'hC:    hex_seg = SEG_C;
      4'hD:    hex_seg = SEG_D;
      4'hE:    hex_seg = SEG_E;
      4'hF:    hex_seg = SEG_F;
      default: hex_seg = SEG_BLANK;
    endcase
  end

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
        default: seg = hex_en ? hex_seg : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: shadow capture, slot
// prescaler, guard interval, leading-zero blanking, registered pin outputs.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SLOT_CYCLES   = 100000,
  parameter int GUARD_CYCLES  = 16,
  parameter int HEX_MODE      = 0,
  parameter int BLANK_LZ      = 1,
  parameter int ANODE_ACT_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLOT_CYCLES - 1);
  localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             HEX_EN    = (HEX_MODE != 0);
  localparam logic             LZ_EN     = (BLANK_LZ != 0);
  localparam logic             AN_LOW    = (ANODE_ACT_LOW != 0);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS out of range 1..8");
  end
  if (SLOT_CYCLES < GUARD_CYCLES + 1) begin : g_bad_slot
    $error("SLOT_CYCLES must exceed GUARD_CYCLES");
  end

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [PRE_W-1:0]           pre;

  logic [NUM_DIGITS-1:0]      lz;
  logic [NUM_DIGITS-1:0]      sel;
  logic [NUM_DIGITS-1:0]      an_on;
  logic [3:0]                 cur_code;
  logic                       cur_blank;
  logic [6:0]                 dec_seg;

  // Scan state: shadow capture is independent of en so loads are never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      pre       <= '0;
      digit_idx <= '0;
    end else begin
      if (load) begin
        shadow    <= bcd_in;
        shadow_dp <= dp_in;
      end
      if (en) begin
        if (pre == PRE_LAST) begin
          pre       <= '0;
          digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  // lz[i]: digits N-1..i of the shadow are all zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (shadow[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (shadow[i] == 4'h0);
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      sel[i] = (digit_idx == IDX_W'(i));
  end

  assign cur_code  = shadow[digit_idx];
  assign cur_blank = LZ_EN && (digit_idx != '0) && lz[digit_idx];
  assign an_on     = (en && (pre >= GUARD_END)) ? sel : '0;

  seven_seg_decode u_dec (
    .code   (cur_code),
    .hex_en (HEX_EN),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  // Pin registers: everything the pins show lags the scan state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment <= SEG_BLANK;
      dp      <= 1'b1;
      anode   <= AN_LOW ? '1 : '0;
    end else begin
      segment <= en ? dec_seg : SEG_BLANK;
      dp      <= en ? ~shadow_dp[digit_idx] : 1'b1;
      anode   <= AN_LOW ? ~an_on : an_on;
    end
  end

endmodule
